// File: rtl/sparkle_pkg.sv
// sparkle_pkg: shared Alzette rotation tables, FSM encoding, round constants and rotate helper.
package sparkle_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [4:0] ALZ_R1 [0:3] = '{5'd31, 5'd17, 5'd0, 5'd24};
    localparam logic [4:0] ALZ_R2 [0:3] = '{5'd24, 5'd17, 5'd31, 5'd16};

    localparam logic [31:0] SPARKLE_RCON [0:7] = '{
        32'hB7E15162, 32'hBF715880, 32'h38B4DA56, 32'h324E7738,
        32'hBB1185EB, 32'h4F7C7B57, 32'hCFBFA1C8, 32'hC2B3293D
    };

    function automatic logic [31:0] rotr(input logic [31:0] v, input logic [4:0] n);
        logic [63:0] t;
        t = {v, v} >> n;
        return t[31:0];
    endfunction

endpackage

// File: rtl/alzette_inv_round.sv
// alzette_inv_round: one combinational inverse Alzette round for forward round index rnd.
module alzette_inv_round
    import sparkle_pkg::*;
(
    input  logic [31:0] x,
    input  logic [31:0] y,
    input  logic [31:0] c,
    input  logic [1:0]  rnd,
    output logic [31:0] nx,
    output logic [31:0] ny
);

    logic [31:0] t;

    assign t  = x ^ c;
    assign ny = y ^ rotr(t, ALZ_R2[rnd]);
    assign nx = t - rotr(ny, ALZ_R1[rnd]);

endmodule

// File: rtl/alzette_inv_iter.sv
// alzette_inv_iter: iterative inverse Alzette, UNROLL inverse rounds per clock,
// valid/ready on both sides, one request in flight at a time.
module alzette_inv_iter
    import sparkle_pkg::*;
#(
    parameter int UNROLL = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_x,
    input  logic [31:0] in_y,
    input  logic [31:0] in_c,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_x,
    output logic [31:0] out_y,
    output logic        busy
);

    if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4) begin : g_bad_unroll
        $error("alzette_inv_iter: UNROLL must be 1, 2 or 4");
    end

    state_t      state, state_n;
    logic [31:0] x_q, y_q, c_q;
    logic [1:0]  rnd_q;
    logic        accept, last;

    logic [UNROLL:0][31:0] xs, ys;

    assign xs[0] = x_q;
    assign ys[0] = y_q;

    // Stage i undoes forward round rnd_q - i, so the chain walks down the schedule.
    for (genvar i = 0; i < UNROLL; i++) begin : g_chain
        alzette_inv_round u_round (
            .x   (xs[i]),
            .y   (ys[i]),
            .c   (c_q),
            .rnd (rnd_q - 2'(i)),
            .nx  (xs[i+1]),
            .ny  (ys[i+1])
        );
    end

    assign accept    = state == IDLE && in_valid && !flush;
    assign last      = rnd_q == 2'(UNROLL - 1);
    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign busy      = state == RUN || state == DONE;
    assign out_x     = x_q;
    assign out_y     = y_q;

    always_comb begin
        state_n = IDLE;
        if (!flush)
            state_n = state == IDLE ? (in_valid  ? RUN  : IDLE) :
                      state == RUN  ? (last      ? DONE : RUN)  :
                      state == DONE ? (out_ready ? IDLE : DONE) : IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            x_q   <= '0;
            y_q   <= '0;
            c_q   <= '0;
            rnd_q <= '0;
        end else begin
            state <= state_n;
            if (flush) begin
                rnd_q <= '0;
            end else if (accept) begin
                x_q   <= in_x;
                y_q   <= in_y;
                c_q   <= in_c;
                rnd_q <= 2'd3;
            end else if (state == RUN) begin
                x_q   <= xs[UNROLL];
                y_q   <= ys[UNROLL];
                rnd_q <= rnd_q - 2'(UNROLL);
            end
        end
    end

endmodule

// File: tb/tb_alzette_inv_iter.sv
// tb_alzette_inv_iter: drives UNROLL = 1, 2, 4 instances against a forward-Alzette
// round-trip model plus directed handshake, flush and reset scenarios.
module tb_alzette_inv_iter;

    logic        clk = 0;
    logic        rst = 1;
    logic        flush = 0;
    logic        out_ready = 1;
    logic [31:0] in_x = 0, in_y = 0, in_c = 0;
    logic        iv [3];
    logic        ir [3];
    logic        ov [3];
    logic        bz [3];
    logic [31:0] ox [3];
    logic [31:0] oy [3];

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        alzette_inv_iter #(.UNROLL(1 << g)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .flush     (flush),
            .in_valid  (iv[g]),
            .in_ready  (ir[g]),
            .in_x      (in_x),
            .in_y      (in_y),
            .in_c      (in_c),
            .out_valid (ov[g]),
            .out_ready (out_ready),
            .out_x     (ox[g]),
            .out_y     (oy[g]),
            .busy      (bz[g])
        );
    end

    localparam logic [31:0] RC [8] = '{
        32'hB7E15162, 32'hBF715880, 32'h38B4DA56, 32'h324E7738,
        32'hBB1185EB, 32'h4F7C7B57, 32'hCFBFA1C8, 32'hC2B3293D
    };
    localparam int FR1 [4] = '{31, 17, 0, 24};
    localparam int FR2 [4] = '{24, 17, 31, 16};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ror(input logic [31:0] v, input int n);
        return n == 0 ? v : (v >> n) | (v << (32 - n));
    endfunction

    // Forward Alzette: the transform this block must undo.
    function automatic logic [63:0] fwd(input logic [31:0] x, input logic [31:0] y, input logic [31:0] c);
        for (int i = 0; i < 4; i++) begin
            x = x + ror(y, FR1[i]);
            y = y ^ ror(x, FR2[i]);
            x = x ^ c;
        end
        return {x, y};
    endfunction

    task automatic xact(input int d, input logic [31:0] x, input logic [31:0] y, input logic [31:0] c,
                        output logic [63:0] res, output int lat);
        in_x = x; in_y = y; in_c = c; iv[d] = 1;
        @(posedge clk); #1;
        iv[d] = 0;
        lat = 0;
        while (!ov[d] && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        res = {ox[d], oy[d]};
        @(posedge clk); #1;
    endtask

    initial begin
        logic [63:0] res, f, held;
        logic [31:0] x, y, c;
        int lat, n, acc_n, acc_cyc[2], hs_cyc, any_ov;
        logic [63:0] q[$];
        logic acc_now;

        for (int d = 0; d < 3; d++) iv[d] = 0;
        #12;
        check("rst_ready", ir[0], 1);
        @(posedge clk); #1;
        rst = 0;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("reset_state_u%0d", 1 << d),
                  {ir[d], ov[d], bz[d], ox[d], oy[d]}, {3'b100, 64'h0});
        end

        for (int d = 0; d < 3; d++) begin
            xact(d, 0, 0, 0, res, lat);
            check($sformatf("zero_lat_u%0d", 1 << d), lat, 4 >> d);
            check($sformatf("zero_out_u%0d", 1 << d), res, 64'h0);
            xact(d, 0, 1, 0, res, lat);
            check($sformatf("hand_lat_u%0d", 1 << d), lat, 4 >> d);
            check($sformatf("hand_out_u%0d", 1 << d), res, 64'hFF020341_00FEBF00);
            check($sformatf("hand_ready_u%0d", 1 << d), ir[d], 1);
        end

        for (int d = 0; d < 3; d++) begin
            n = d == 0 ? 6000 : 2000;
            for (int k = 0; k < n; k++) begin
                x = $urandom; y = $urandom; c = RC[$urandom_range(0, 7)];
                f = fwd(x, y, c);
                xact(d, f[63:32], f[31:0], c, res, lat);
                check($sformatf("roundtrip_u%0d", 1 << d), res, {x, y});
            end
        end

        // Backpressure: result must hold and new requests be refused while stalled.
        x = 32'h12345678; y = 32'h9ABCDEF0; c = RC[3];
        f = fwd(x, y, c);
        out_ready = 0;
        in_x = f[63:32]; in_y = f[31:0]; in_c = c; iv[0] = 1;
        @(posedge clk); #1;
        iv[0] = 0;
        lat = 0;
        while (!ov[0] && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("bp_lat", lat, 4);
        held = {ox[0], oy[0]};
        check("bp_result", held, {x, y});
        in_x = 32'hDEADBEEF; in_y = 32'hCAFEF00D; iv[0] = 1;
        for (int k = 0; k < 7; k++) begin
            @(posedge clk); #1;
            check("bp_hold", {ov[0], ir[0], ox[0], oy[0]}, {2'b10, held});
        end
        iv[0] = 0;
        out_ready = 1;
        @(posedge clk); #1;
        check("bp_release", {ir[0], ov[0], bz[0]}, 3'b100);

        // Flush in RUN cycle 2 with a competing request.
        f = fwd(32'h0BADF00D, 32'h600DCAFE, RC[0]);
        in_x = f[63:32]; in_y = f[31:0]; in_c = RC[0]; iv[0] = 1;
        @(posedge clk); #1;
        iv[0] = 0;
        @(posedge clk); #1;
        flush = 1; iv[0] = 1;
        @(posedge clk); #1;
        flush = 0; iv[0] = 0;
        check("flush_idle", {ir[0], bz[0], ov[0]}, 3'b100);
        any_ov = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (ov[0] || !ir[0]) any_ov++;
        end
        check("flush_no_out", any_ov, 0);

        // Asynchronous reset mid-RUN.
        f = fwd(32'h11111111, 32'h22222222, RC[5]);
        in_x = f[63:32]; in_y = f[31:0]; in_c = RC[5]; iv[0] = 1;
        @(posedge clk); #1;
        iv[0] = 0;
        check("pre_rst_busy", bz[0], 1);
        #2 rst = 1;
        #1;
        check("rst_async", {ir[0], ov[0], bz[0], ox[0], oy[0]}, {3'b100, 64'h0});
        @(posedge clk); #1;
        rst = 0;
        @(posedge clk); #1;
        check("rst_after", {ir[0], ov[0], bz[0]}, 3'b100);

        // Back-to-back with out_ready high.
        x = 32'hA5A5A5A5; y = 32'h5A5A5A5A; c = RC[6];
        f = fwd(x, y, c);
        res = fwd(32'h01234567, 32'h89ABCDEF, RC[7]);
        in_x = f[63:32]; in_y = f[31:0]; in_c = c; iv[0] = 1;
        acc_n = 0; hs_cyc = -1; acc_cyc[0] = -1; acc_cyc[1] = -1;
        for (int k = 0; k < 30; k++) begin
            if (ov[0]) begin
                q.push_back({ox[0], oy[0]});
                if (hs_cyc < 0) hs_cyc = k;
            end
            acc_now = ir[0] && iv[0];
            if (acc_now) acc_cyc[acc_n] = k;
            @(posedge clk); #1;
            if (acc_now) begin
                acc_n++;
                if (acc_n == 1) begin
                    in_x = res[63:32]; in_y = res[31:0]; in_c = RC[7];
                end else iv[0] = 0;
            end
        end
        iv[0] = 0;
        check("b2b_count", q.size(), 2);
        check("b2b_second_accept", acc_cyc[1], hs_cyc + 1);
        if (q.size() >= 2) begin
            check("b2b_first", q[0], {x, y});
            check("b2b_second", q[1], {32'h01234567, 32'h89ABCDEF});
        end

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
